// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch front end. Issues word-aligned fetch requests,
// tracks responses in flight, buffers returned instructions with their PCs and
// handles redirects by flushing the buffer and draining stale responses.
// Optional build macro: FETCH_STATS_EN adds the stall_cycles counter output.
//
// state | meaning
// FETCH | issuing requests and pushing responses into the buffer
// DRAIN | discarding responses of an abandoned stream until none are in flight

module fetch_unit #(
  parameter int                    DATA_WIDTH = 32,
  parameter int                    DEPTH      = 4,
  parameter logic [DATA_WIDTH-1:0] RESET_PC   = 32'h0000_0000
) (
  input  logic                  clk,
  input  logic                  rst,
  output logic                  imem_req_valid,
  output logic [DATA_WIDTH-1:0] imem_req_addr,
  input  logic                  imem_req_ready,
  input  logic                  imem_rsp_valid,
  input  logic [DATA_WIDTH-1:0] imem_rsp_data,
  input  logic                  redirect_valid,
  input  logic [DATA_WIDTH-1:0] redirect_pc,
  output logic                  instr_valid,
  output logic [DATA_WIDTH-1:0] instr,
  output logic [DATA_WIDTH-1:0] instr_pc,
`ifdef FETCH_STATS_EN
  output logic [31:0]           stall_cycles,
`endif
  input  logic                  instr_ready
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W:0] DEPTH_L = (CNT_W + 1)'(DEPTH);

  typedef enum logic {
    FETCH = 1'b0,
    DRAIN = 1'b1
  } state_t;

  state_t                  state;
  logic [DATA_WIDTH-1:0]   fetch_pc;
  logic [DATA_WIDTH-1:0]   rsp_pc;
  logic [CNT_W-1:0]        outstanding;
  logic [CNT_W-1:0]        out_next;
  logic [CNT_W-1:0]        count;
  logic [PTR_W-1:0]        head;
  logic [PTR_W-1:0]        tail;
  logic [CNT_W:0]          occupancy;
  logic [DATA_WIDTH-1:0]   redirect_tgt;
  logic                    req_hs;
  logic                    push;
  logic                    pop;

  logic [DATA_WIDTH-1:0]   ent_data [DEPTH];
  logic [DATA_WIDTH-1:0]   ent_pc   [DEPTH];

  // Low two bits of the redirect target are forced to zero (word aligned).
  assign redirect_tgt = redirect_pc & ~(DATA_WIDTH'(3));

  // Buffered plus in-flight words may never exceed the buffer size, so every
  // response always has a slot waiting for it.
  assign occupancy = {1'b0, count} + {1'b0, outstanding};

  assign imem_req_valid = rst & (state == FETCH) & ~redirect_valid & (occupancy < DEPTH_L);
  assign imem_req_addr  = fetch_pc;

  assign req_hs = imem_req_valid & imem_req_ready;
  assign pop    = instr_valid & instr_ready;
  // A response arriving with a redirect belongs to the old stream.
  assign push   = (state == FETCH) & imem_rsp_valid & ~redirect_valid;

  assign instr_valid = (count != '0);
  assign instr       = instr_valid ? ent_data[head] : '0;
  assign instr_pc    = instr_valid ? ent_pc[head]   : '0;

  // Next in-flight count: a request and a response in the same cycle cancel.
  always_comb begin
    out_next = outstanding;
    if (req_hs && !imem_rsp_valid) begin
      out_next = outstanding + CNT_W'(1);
    end else if (!req_hs && imem_rsp_valid) begin
      out_next = outstanding - CNT_W'(1);
    end
  end

  // Control FSM, fetch/response PCs and in-flight request count.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= FETCH;
      fetch_pc    <= RESET_PC;
      rsp_pc      <= RESET_PC;
      outstanding <= '0;
    end else begin
      outstanding <= out_next;
      if (redirect_valid) begin
        fetch_pc <= redirect_tgt;
        rsp_pc   <= redirect_tgt;
        state    <= (out_next != '0) ? DRAIN : FETCH;
      end else begin
        if (req_hs) begin
          fetch_pc <= fetch_pc + DATA_WIDTH'(4);
        end
        if (push) begin
          rsp_pc <= rsp_pc + DATA_WIDTH'(4);
        end
        if ((state == DRAIN) && (out_next == '0)) begin
          state <= FETCH;
        end
      end
    end
  end

  // Buffer pointers and fill level; a redirect empties the buffer after any
  // same-cycle consume has been taken by the CPU.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else if (redirect_valid) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (push) begin
        tail <= tail + PTR_W'(1);
      end
      if (pop) begin
        head <= head + PTR_W'(1);
      end
      if (push && !pop) begin
        count <= count + CNT_W'(1);
      end else if (pop && !push) begin
        count <= count - CNT_W'(1);
      end
    end
  end

  // Buffer storage: instruction word tagged with the PC it was fetched from.
  always_ff @(posedge clk) begin
    if (push) begin
      ent_data[tail] <= imem_rsp_data;
      ent_pc[tail]   <= rsp_pc;
    end
  end

`ifdef FETCH_STATS_EN
  // Count cycles where the CPU could take an instruction but none is ready.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cycles <= '0;
    end else if (!instr_valid && instr_ready && (stall_cycles != '1)) begin
      stall_cycles <= stall_cycles + 32'd1;
    end
  end
`endif

endmodule
